reg4x4_arb: RTL

Round-robin access controller for the 4x4 register file. It shares the file's single ce/we/add/dIn port between three requesters over a fully registered req/gnt handshake and returns read data. It also runs a 4-cycle clear sequencer that zeroes all four registers. It sits directly in front of reg4x4 and drives every one of that block's control and data inputs.

---
 rtl/reg4x4_arb_pkg.sv | 11 +
 rtl/reg4x4_arb_rr_arb3.sv | 19 +
 rtl/reg4x4_arb.sv | 107 ++++++++++
 3 files changed

// File: rtl/reg4x4_arb_pkg.sv
// reg4x4_arb_pkg: shared types, sizes and round-robin helper for reg4x4_arb
package reg4x4_arb_pkg;
    localparam int NREQ  = 3;
    localparam int AW    = 2;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    typedef enum logic [1:0] {IDLE, ACC, CLR} state_t;
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/reg4x4_arb_rr_arb3.sv
// rr_arb3: combinational round-robin picker over three requesters
module rr_arb3
    import reg4x4_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);
    logic [1:0] c0, c1, c2;
    // candidates in priority order starting just after the last winner
    always_comb begin
        c0    = rr_next(ptr);
        c1    = rr_next(c0);
        c2    = rr_next(c1);
        valid = |req;
        idx   = req[c0] ? c0 : req[c1] ? c1 : c2;
    end
endmodule

// File: rtl/reg4x4_arb.sv
// reg4x4_arb: round-robin access controller and clear sequencer for reg4x4
module reg4x4_arb
    import reg4x4_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      wr,
    input  logic [NREQ*AW-1:0]   reqAdd,
    input  logic [NREQ*DW-1:0]   reqDat,
    input  logic                 clr,
    output logic [NREQ-1:0]      gnt,
    output logic                 rdVld,
    output logic [DW-1:0]        rdDat,
    output logic                 busy,
    output logic                 rfCe,
    output logic                 rfWe,
    output logic [AW-1:0]        rfAdd,
    output logic [DW-1:0]        rfDIn,
    input  logic [DEPTH*DW-1:0]  rfDOut
);
    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n, cnt, cnt_n, w, w_n, idx;
    logic          clr_pend, clr_pend_n, wr_l, wr_l_n, valid;
    logic [AW-1:0] add_l, add_l_n;
    logic [DW-1:0] dat_l, dat_l_n;

    rr_arb3 u_arb (.req(req), .ptr(ptr), .valid(valid), .idx(idx));

    // next state, winner latch, clear counter and pending-clear flag
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cnt_n      = cnt;
        w_n        = w;
        wr_l_n     = wr_l;
        add_l_n    = add_l;
        dat_l_n    = dat_l;
        clr_pend_n = clr_pend;
        case (state)
            IDLE: begin
                if (clr_pend || clr) begin
                    state_n    = CLR;
                    cnt_n      = '0;
                    clr_pend_n = 1'b0;
                end else if (valid) begin
                    state_n = ACC;
                    ptr_n   = idx;
                    w_n     = idx;
                    wr_l_n  = wr[idx];
                    add_l_n = reqAdd[AW*idx +: AW];
                    dat_l_n = wr[idx] ? reqDat[DW*idx +: DW] : '0;
                end
            end
            ACC: begin
                state_n    = IDLE;
                clr_pend_n = clr_pend | clr;
            end
            CLR: begin
                cnt_n      = cnt + 2'd1;
                clr_pend_n = 1'b0;
                state_n    = (cnt == 2'd3) ? IDLE : CLR;
            end
            default: state_n = IDLE;
        endcase
    end

    // state and registered Moore outputs derived from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= 2'd2;
            cnt      <= '0;
            w        <= '0;
            wr_l     <= 1'b0;
            add_l    <= '0;
            dat_l    <= '0;
            clr_pend <= 1'b0;
            gnt      <= '0;
            rdVld    <= 1'b0;
            rdDat    <= '0;
            busy     <= 1'b0;
            rfCe     <= 1'b0;
            rfWe     <= 1'b0;
            rfAdd    <= '0;
            rfDIn    <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            w        <= w_n;
            wr_l     <= wr_l_n;
            add_l    <= add_l_n;
            dat_l    <= dat_l_n;
            clr_pend <= clr_pend_n;
            gnt      <= (state_n == ACC) ? NREQ'(1) << w_n : '0;
            busy     <= state_n == CLR;
            rfCe     <= state_n != IDLE;
            rfWe     <= (state_n == CLR) || (state_n == ACC && wr_l_n);
            rfAdd    <= (state_n == CLR) ? cnt_n : (state_n == ACC) ? add_l_n : '0;
            rfDIn    <= (state_n == ACC) ? dat_l_n : '0;
            rdVld    <= state == ACC && !wr_l;
            if (state == ACC && !wr_l)
                rdDat <= rfDOut[DW*rfAdd +: DW];
        end
    end
endmodule
